// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress
// Write-side ingress stage of the async FIFO, wclk domain. A 2-entry skid
// buffer takes a valid/ready source stream and presents it to the write-pointer
// stage as winc/wdata. The Gray write pointer and the synchronised Gray read
// pointer are decoded into a registered fill level and almost-full flag.
// Saturating statistics count written words and full-stall cycles.
//
// State table:
//   state | meaning
//   EMPTY | no word buffered, winc low
//   ONE   | head holds a word, presented on wdata with winc high
//   TWO   | head and skid both hold words, s_ready low
//
// Ports:
//   wclk, wrst        clock, synchronous active-high reset
//   s_valid/s_data    source word in, s_ready back to source
//   winc/wdata        write request and word to the FIFO pointer/memory stage
//   wfull             registered full flag from the pointer stage
//   wptr, wq2_rptr    Gray write pointer and synchronised Gray read pointer
//   wlevel            registered fill level 0..2^ADDRSIZE
//   walmost_full      registered (level >= AFULL_THRESH), aligned with wlevel
//   wr_count          saturating count of words written (winc & ~wfull)
//   stall_count       saturating count of cycles with winc & wfull
module fifo_wr_ingress #(
  parameter int DSIZE        = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                s_valid,
  input  logic [DSIZE-1:0]    s_data,
  output logic                s_ready,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic [15:0]         wr_count,
  output logic [15:0]         stall_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

  state_t           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             accept, pop;
  logic [ADDRSIZE:0] wbin, rbin, level_next;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign s_ready = (state_q != TWO) & ~wrst;
  assign winc    = (state_q != EMPTY);
  assign wdata   = head_q;
  assign accept  = s_valid & s_ready;
  // Same gating the pointer stage applies, so pop marks a word truly written.
  assign pop     = winc & ~wfull;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = s_data;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = s_data;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = s_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Modulo-2^(ADDRSIZE+1) difference handles the MSB wrap of either pointer.
  assign wbin       = gray2bin(wptr);
  assign rbin       = gray2bin(wq2_rptr);
  assign level_next = wbin - rbin;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_next;
      walmost_full <= (level_next >= AFULL_LVL);
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (winc && wfull && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Testbench for fifo_wr_ingress: scoreboard on the word stream plus a
// table of pointer pairs for the level decode, and hand-written sequences
// for reset, streaming, backpressure, saturation and mid-operation reset.
module tb_fifo_wr_ingress;

  logic        wclk = 1'b0;
  logic        wrst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic [4:0]  wptr;
  logic [4:0]  wq2_rptr;
  logic [4:0]  wlevel;
  logic        walmost_full;
  logic [15:0] wr_count;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q[$];

  fifo_wr_ingress #(.DSIZE(8), .ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .wptr(wptr), .wq2_rptr(wq2_rptr), .wlevel(wlevel),
    .walmost_full(walmost_full), .wr_count(wr_count),
    .stall_count(stall_count)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] bin2gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  // Scoreboard: inputs are stable by the falling edge, so the handshakes seen
  // here are exactly the ones the next rising edge will act on.
  always @(negedge wclk) begin
    if (wrst === 1'b1) begin
      sb_q.delete();
    end else if (wrst === 1'b0) begin
      if (winc && !wfull) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", {24'd0, wdata}, 32'hDEAD);
        end else begin
          chk("sb_wdata", {24'd0, wdata}, {24'd0, sb_q.pop_front()});
        end
      end
      if (s_valid && s_ready) sb_q.push_back(s_data);
    end
  end

  typedef struct {
    int         wb;
    int         rb;
    logic [4:0] lvl;
    logic       af;
  } lvl_vec_t;

  lvl_vec_t lv[9];

  initial begin
    lv[0] = '{wb: 1,  rb: 17, lvl: 5'd16, af: 1'b1};
    lv[1] = '{wb: 20, rb: 9,  lvl: 5'd11, af: 1'b0};
    lv[2] = '{wb: 0,  rb: 0,  lvl: 5'd0,  af: 1'b0};
    lv[3] = '{wb: 12, rb: 0,  lvl: 5'd12, af: 1'b1};
    lv[4] = '{wb: 11, rb: 0,  lvl: 5'd11, af: 1'b0};
    lv[5] = '{wb: 3,  rb: 30, lvl: 5'd5,  af: 1'b0};
    lv[6] = '{wb: 28, rb: 16, lvl: 5'd12, af: 1'b1};
    lv[7] = '{wb: 16, rb: 16, lvl: 5'd0,  af: 1'b0};
    lv[8] = '{wb: 31, rb: 15, lvl: 5'd16, af: 1'b1};

    wrst = 1'b1; s_valid = 1'b1; s_data = 8'h55; wfull = 1'b0;
    wptr = '0; wq2_rptr = '0;

    // Reset held for two edges with s_valid high.
    tick(); tick();
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_winc", {31'd0, winc}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("rst_wlevel", {27'd0, wlevel}, 32'd0);
    chk("rst_afull", {31'd0, walmost_full}, 32'd0);
    wrst = 1'b0; s_valid = 1'b0;
    tick();
    #1;
    chk("rel_s_ready", {31'd0, s_ready}, 32'd1);

    // Streaming 0x01..0x14, no backpressure.
    for (int i = 1; i <= 20; i++) begin
      s_valid = 1'b1; s_data = i[7:0];
      #1;
      if (i >= 2) chk("stream_winc", {31'd0, winc}, 32'd1);
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    #1;
    chk("stream_wr_count", {16'd0, wr_count}, 32'd20);
    chk("stream_drained", sb_q.size(), 32'd0);
    chk("stream_idle_winc", {31'd0, winc}, 32'd0);

    // Backpressure: wfull high for six edges, winc high on the last five.
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA1;
    tick();
    s_data = 8'hA2;
    tick();
    s_data = 8'hA3;
    #1;
    chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_wdata_hold", {24'd0, wdata}, 32'hA1);
      chk("bp_winc_hold", {31'd0, winc}, 32'd1);
      tick();
    end
    #1;
    chk("bp_stall_count", {16'd0, stall_count}, 32'd5);
    chk("bp_wr_count", {16'd0, wr_count}, 32'd20);
    wfull = 1'b0; s_valid = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("bp_wr_count_after", {16'd0, wr_count}, 32'd22);
    chk("bp_drained", sb_q.size(), 32'd0);

    // Level decode table; each result appears one edge after the pointers.
    for (int i = 0; i < 9; i++) begin
      wptr = bin2gray(lv[i].wb);
      wq2_rptr = bin2gray(lv[i].rb);
      #1;
      if (i > 0) chk("lvl_latency", {27'd0, wlevel}, {27'd0, lv[i-1].lvl});
      tick();
      #1;
      chk("lvl_value", {27'd0, wlevel}, {27'd0, lv[i].lvl});
      chk("lvl_afull", {31'd0, walmost_full}, {31'd0, lv[i].af});
    end
    wptr = '0; wq2_rptr = '0;

    // Saturation of wr_count.
    for (int i = 0; i < 65540; i++) begin
      s_valid = 1'b1; s_data = i[7:0];
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    #1;
    chk("sat_wr_count", {16'd0, wr_count}, 32'hFFFF);
    chk("sat_drained", sb_q.size(), 32'd0);

    // Mid-operation reset while in TWO under wfull.
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hB1;
    tick();
    s_data = 8'hB2;
    tick();
    s_valid = 1'b0;
    #1;
    chk("mid_two_s_ready", {31'd0, s_ready}, 32'd0);
    wrst = 1'b1;
    #1;
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    #1;
    chk("mid_rst_winc", {31'd0, winc}, 32'd0);
    wrst = 1'b0; wfull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("mid_post_winc", {31'd0, winc}, 32'd0);
      chk("mid_post_wdata", {24'd0, wdata}, 32'd0);
    end
    chk("mid_wr_count", {16'd0, wr_count}, 32'd0);
    chk("mid_stall_count", {16'd0, stall_count}, 32'd0);
    chk("mid_s_ready", {31'd0, s_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
